// File: rtl/jzjpcc_fetch_stage.sv
// Fetch stage of the pipelined core: owns the PC, applies execute redirects,
// and feeds the fetch/decode pipeline register with bubbles on flush or halt.
module jzjpcc_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR    = 32'h00000000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_fetch,
  input  logic        flush_decode,
  input  logic        branchTaken_execute,
  input  logic [31:0] branchTarget_execute,
  input  logic        haltRequest,
  input  logic [31:0] instruction_fetch,
  output logic [31:0] instructionAddress_fetch,
  output logic [31:0] instruction_decode,
  output logic [31:0] pc_decode,
  output logic [31:0] pcPlus4_decode,
  output logic        valid_decode,
  output logic        halted,
  output logic        misalignedTarget
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state, state_next;
  logic        set_misaligned;
  logic        misaligned_redirect;
  logic [31:0] pc, pc_next, pc_plus4;
  logic [31:0] instr_next, pcd_next, pcp4_next;
  logic        valid_next;

  assign misaligned_redirect      = branchTaken_execute && (branchTarget_execute[1:0] != 2'b00);
  assign pc_plus4                 = pc + 32'd4;
  assign instructionAddress_fetch = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // A simultaneous halt request wins, so the misaligned flag stays clear then.
  always_comb begin
    state_next     = state;
    set_misaligned = 1'b0;
    if (state == RUN) begin
      if (haltRequest) begin
        state_next = HALTED;
      end else if (misaligned_redirect) begin
        state_next     = HALTED;
        set_misaligned = 1'b1;
      end
    end
  end

  always_comb begin
    halted = (state == HALTED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)               misalignedTarget <= 1'b0;
    else if (set_misaligned) misalignedTarget <= 1'b1;
  end

  always_comb begin
    pc_next    = pc;
    instr_next = instruction_decode;
    pcd_next   = pc_decode;
    pcp4_next  = pcPlus4_decode;
    valid_next = valid_decode;
    if ((state == HALTED) || haltRequest) begin
      instr_next = NOP_INSTRUCTION;
      valid_next = 1'b0;
    end else begin
      if (misaligned_redirect)      pc_next = pc;
      else if (branchTaken_execute) pc_next = branchTarget_execute;
      else if (!stall_fetch)        pc_next = pc_plus4;

      if (flush_decode) begin
        instr_next = NOP_INSTRUCTION;
        valid_next = 1'b0;
      end else if (!stall_fetch) begin
        instr_next = instruction_fetch;
        pcd_next   = pc;
        pcp4_next  = pc_plus4;
        valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc                 <= RESET_VECTOR;
      instruction_decode <= NOP_INSTRUCTION;
      pc_decode          <= '0;
      pcPlus4_decode     <= '0;
      valid_decode       <= 1'b0;
    end else begin
      pc                 <= pc_next;
      instruction_decode <= instr_next;
      pc_decode          <= pcd_next;
      pcPlus4_decode     <= pcp4_next;
      valid_decode       <= valid_next;
    end
  end

endmodule

// File: tb/tb_jzjpcc_fetch_stage.sv
// Directed bench for jzjpcc_fetch_stage: expected results are queued when a
// step is driven and popped for comparison once the DUT has clocked it.
module tb_jzjpcc_fetch_stage;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    logic        valid;
    logic        halted;
    logic        mis;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_fetch = 1'b0;
  logic        flush_decode = 1'b0;
  logic        branchTaken_execute = 1'b0;
  logic [31:0] branchTarget_execute = '0;
  logic        haltRequest = 1'b0;
  logic [31:0] instruction_fetch;
  logic [31:0] instructionAddress_fetch;
  logic [31:0] instruction_decode;
  logic [31:0] pc_decode;
  logic [31:0] pcPlus4_decode;
  logic        valid_decode;
  logic        halted;
  logic        misalignedTarget;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        sb[$];

  localparam logic [31:0] NOP = 32'h00000013;

  jzjpcc_fetch_stage #(.RESET_VECTOR(32'h00000100), .NOP_INSTRUCTION(NOP)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .stall_fetch              (stall_fetch),
    .flush_decode             (flush_decode),
    .branchTaken_execute      (branchTaken_execute),
    .branchTarget_execute     (branchTarget_execute),
    .haltRequest              (haltRequest),
    .instruction_fetch        (instruction_fetch),
    .instructionAddress_fetch (instructionAddress_fetch),
    .instruction_decode       (instruction_decode),
    .pc_decode                (pc_decode),
    .pcPlus4_decode           (pcPlus4_decode),
    .valid_decode             (valid_decode),
    .halted                   (halted),
    .misalignedTarget         (misalignedTarget)
  );

  // Memory image: every word reads back as 0xA0 + its address.
  assign instruction_fetch = 32'h000000A0 + instructionAddress_fetch;

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_push(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                             input logic [31:0] pcd, input logic [31:0] pcp4,
                             input logic valid, input logic h, input logic m);
    exp_t e;
    e.tag = tag; e.addr = addr; e.instr = instr; e.pcd = pcd; e.pcp4 = pcp4;
    e.valid = valid; e.halted = h; e.mis = m;
    sb.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".addr"},   instructionAddress_fetch, e.addr);
    chk({e.tag, ".instr"},  instruction_decode,       e.instr);
    chk({e.tag, ".pcd"},    pc_decode,                e.pcd);
    chk({e.tag, ".pcp4"},   pcPlus4_decode,           e.pcp4);
    chk({e.tag, ".valid"},  {31'd0, valid_decode},     {31'd0, e.valid});
    chk({e.tag, ".halted"}, {31'd0, halted},           {31'd0, e.halted});
    chk({e.tag, ".mis"},    {31'd0, misalignedTarget}, {31'd0, e.mis});
  endtask

  // Drive one cycle's inputs, queue what must be visible after the edge, then check.
  task automatic step(input string tag, input logic st, input logic fl, input logic br,
                      input logic [31:0] tgt, input logic hr,
                      input logic [31:0] addr, input logic [31:0] instr,
                      input logic [31:0] pcd, input logic [31:0] pcp4,
                      input logic valid, input logic h, input logic m);
    stall_fetch = st; flush_decode = fl; branchTaken_execute = br;
    branchTarget_execute = tgt; haltRequest = hr;
    expect_push(tag, addr, instr, pcd, pcp4, valid, h, m);
    @(posedge clock);
    #1;
    compare_pop();
  endtask

  initial begin
    #12;
    expect_push("reset", 32'h100, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    compare_pop();
    reset = 1'b0;

    //    tag        st fl br target        hr   addr          instr         pcd           pcp4          v  h  m
    step("run1",     0, 0, 0, 32'h0,        0,   32'h104,      32'h1A0,      32'h100,      32'h104,      1, 0, 0);
    step("run2",     0, 0, 0, 32'h0,        0,   32'h108,      32'h1A4,      32'h104,      32'h108,      1, 0, 0);
    step("stall1",   1, 0, 0, 32'h0,        0,   32'h108,      32'h1A4,      32'h104,      32'h108,      1, 0, 0);
    step("stall2",   1, 0, 0, 32'h0,        0,   32'h108,      32'h1A4,      32'h104,      32'h108,      1, 0, 0);
    step("resume",   0, 0, 0, 32'h0,        0,   32'h10C,      32'h1A8,      32'h108,      32'h10C,      1, 0, 0);
    step("redir",    0, 1, 1, 32'h200,      0,   32'h200,      NOP,          32'h108,      32'h10C,      0, 0, 0);
    step("redir_t",  0, 0, 0, 32'h0,        0,   32'h204,      32'h2A0,      32'h200,      32'h204,      1, 0, 0);
    step("redir_st", 1, 1, 1, 32'h200,      0,   32'h200,      NOP,          32'h200,      32'h204,      0, 0, 0);
    step("redir_t2", 0, 0, 0, 32'h0,        0,   32'h204,      32'h2A0,      32'h200,      32'h204,      1, 0, 0);
    step("run3",     0, 0, 0, 32'h0,        0,   32'h208,      32'h2A4,      32'h204,      32'h208,      1, 0, 0);
    step("halt",     0, 0, 0, 32'h0,        1,   32'h208,      NOP,          32'h204,      32'h208,      0, 1, 0);
    step("halt_ign", 1, 1, 1, 32'h300,      0,   32'h208,      NOP,          32'h204,      32'h208,      0, 1, 0);

    stall_fetch = 0; flush_decode = 0; branchTaken_execute = 0; haltRequest = 0;
    #2 reset = 1'b1;
    #1;
    expect_push("async_rst", 32'h100, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    compare_pop();
    #1 reset = 1'b0;

    step("rerun",    0, 0, 0, 32'h0,        0,   32'h104,      32'h1A0,      32'h100,      32'h104,      1, 0, 0);
    step("to_top",   0, 1, 1, 32'hFFFFFFFC, 0,   32'hFFFFFFFC, NOP,          32'h100,      32'h104,      0, 0, 0);
    step("wrap",     0, 0, 0, 32'h0,        0,   32'h0,        32'h0000009C, 32'hFFFFFFFC, 32'h0,        1, 0, 0);
    step("post_wrap",0, 0, 0, 32'h0,        0,   32'h4,        32'hA0,       32'h0,        32'h4,        1, 0, 0);
    step("misalign", 0, 1, 1, 32'h202,      0,   32'h4,        NOP,          32'h0,        32'h4,        0, 1, 1);
    step("mis_ign",  0, 0, 1, 32'h200,      0,   32'h4,        NOP,          32'h0,        32'h4,        0, 1, 1);
    step("mis_hold", 0, 0, 0, 32'h0,        0,   32'h4,        NOP,          32'h0,        32'h4,        0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
